// File: rtl/toeplitz_acc_if.sv
// Raw-bit input stream and hash output stream of toeplitz_acc.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface toeplitz_acc_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned L  = 128
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [L-1:0]  out_hash;
  logic          out_valid;
  logic          out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_hash, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_hash, out_valid
  );
endinterface

// File: rtl/toeplitz_acc.sv
// Double-buffered GF(2) Toeplitz hash: XOR-accumulates gencol columns selected by raw bits,
// steering gencol's reset so column 0 lines up with the first RUN cycle.
module toeplitz_acc #(
  parameter int unsigned N  = 256,
  parameter int unsigned L  = 128,
  parameter int unsigned DW = 8
) (
  input  logic                clk,
  input  logic                reset,
  toeplitz_acc_if.slave       bus,
  output logic                gen_rst,
  input  logic [L-1:0]        col
);

  localparam int unsigned WORDS = N / DW;
  localparam int unsigned FW    = $clog2(WORDS + 1);
  localparam int unsigned WIW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned KW    = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [WORDS-1:0][DW-1:0]  fbuf;
  logic [FW-1:0]             fcnt;
  logic [N-1:0]              pbuf;
  logic [L-1:0]              acc;
  logic [L-1:0]              hash_q;
  logic                      valid_q;
  logic [KW-1:0]             k;

  logic full_c;
  logic accept_c;
  logic copy_c;
  logic arm_c;
  logic run_c;
  logic load_c;

  assign full_c        = (fcnt == FW'(WORDS));
  assign accept_c      = bus.in_valid && !full_c;
  assign bus.in_ready  = !full_c;
  assign bus.out_hash  = hash_q;
  assign bus.out_valid = valid_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d = state_q;
    copy_c  = 1'b0;
    arm_c   = 1'b0;
    run_c   = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_c) begin
          copy_c  = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        arm_c   = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        run_c = 1'b1;
        if (k == KW'(N - 1)) state_d = DONE;
      end
      DONE: begin
        if (!valid_q || bus.out_ready) begin
          load_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Data buffers carry no reset; only fcnt decides what is valid
  always_ff @(posedge clk) begin
    if (accept_c) fbuf[WIW'(fcnt)] <= bus.in_data;
    if (copy_c)   pbuf             <= fbuf;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcnt <= '0;
    end else if (copy_c) begin
      fcnt <= '0;
    end else if (accept_c) begin
      fcnt <= fcnt + 1'b1;
    end
  end

  // gencol is held in reset through ARM so it presents column 0 on the first RUN cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) gen_rst <= 1'b1;
    else        gen_rst <= copy_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      k   <= '0;
    end else if (arm_c) begin
      acc <= '0;
      k   <= '0;
    end else if (run_c) begin
      acc <= acc ^ (pbuf[k] ? col : '0);
      k   <= k + 1'b1;
    end
  end

  // Output register: a DONE reload during a transfer keeps valid high with the new hash
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hash_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_c) begin
      hash_q  <= acc;
      valid_q <= 1'b1;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_toeplitz_acc.sv
// Scoreboard bench for toeplitz_acc with a behavioural gencol column generator.
module tb_toeplitz_acc;
  localparam int unsigned N     = 256;
  localparam int unsigned L     = 128;
  localparam int unsigned DW    = 8;
  localparam int unsigned WORDS = N / DW;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic gen_rst;
  logic [L-1:0] col;

  always #5 clk = ~clk;

  toeplitz_acc_if #(.DW(DW), .L(L)) bus ();

  toeplitz_acc #(.N(N), .L(L), .DW(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .gen_rst (gen_rst),
    .col     (col)
  );

  // Behavioural gencol: shift register loaded with col0/row0, free-running wrap every N cycles
  logic [N-1:0] row0;
  logic [L-1:0] col0;
  logic [N-1:0] rsh;
  int unsigned  gcnt;

  always @(posedge clk) begin
    if (gen_rst || gcnt == N - 1) begin
      col  <= col0;
      rsh  <= row0;
      gcnt <= 0;
    end else begin
      col  <= {rsh[N-1], col[L-1:1]};
      rsh  <= rsh << 1;
      gcnt <= gcnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nout   = 0;
  logic [L-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_vec(input string name, input logic [L-1:0] act, input logic [L-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Reference: column j of the Toeplitz matrix built directly from col0/row0
  function automatic logic [L-1:0] colj(input int j);
    logic [L-1:0] c;
    for (int i = 0; i < L; i++) begin
      if (i + j < L) c[i] = col0[i + j];
      else           c[i] = row0[N - 1 - (i + j - L)];
    end
    return c;
  endfunction

  function automatic logic [L-1:0] ref_hash(input logic [N-1:0] x);
    logic [L-1:0] h = '0;
    for (int j = 0; j < N; j++) if (x[j]) h ^= colj(j);
    return h;
  endfunction

  function automatic logic [N-1:0] rnd();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Monitor: pops expected hashes on every transfer and checks hold stability under stall
  initial begin
    logic         prev_stall;
    logic [L-1:0] prev_hash;
    logic [L-1:0] e;
    prev_stall = 1'b0;
    prev_hash  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && bus.out_valid) check_vec("hold", bus.out_hash, prev_hash);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h required no output", bus.out_hash);
          end else begin
            e = exp_q.pop_front();
            check_vec($sformatf("hash%0d", nout), bus.out_hash, e);
          end
          nout++;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_hash  = bus.out_hash;
      end
    end
  end

  task automatic send_word(input logic [DW-1:0] d);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 required 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [N-1:0] blk, input int maxgap);
    for (int w = 0; w < WORDS; w++) begin
      int gap = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
      if (gap > 0) begin
        bus.in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      send_word(blk[w*DW +: DW]);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic push_send(input logic [N-1:0] blk, input int maxgap);
    exp_q.push_back(ref_hash(blk));
    send_block(blk, maxgap);
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check_int("drain", int'(ok), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] blk;
    logic [N-1:0] tmp;
    int t0, lat, n0, stall;
    int rise[3];

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    row0 = rnd();
    tmp  = rnd();
    col0 = tmp[L-1:0];

    repeat (3) @(posedge clk);
    #1;
    check_int("rst_out_valid", int'(bus.out_valid), 0);
    check_vec("rst_out_hash", bus.out_hash, '0);
    check_int("rst_gen_rst", int'(gen_rst), 1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check_int("rel_gen_rst", int'(gen_rst), 0);
    check_int("rel_in_ready", int'(bus.in_ready), 1);

    // All-zero block and first-result latency
    exp_q.push_back('0);
    send_block('0, 0);
    t0  = cyc;
    lat = -1;
    for (int t = 0; t < 600; t++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = cyc - t0;
        break;
      end
    end
    check_int("latency", lat, N + 3);
    wait_drain();

    // Single-bit blocks pick out column 0 and column 1
    blk = '0;
    blk[0] = 1'b1;
    exp_q.push_back(col0);
    send_block(blk, 0);
    blk = '0;
    blk[1] = 1'b1;
    exp_q.push_back({row0[N-1], col0[L-1:1]});
    send_block(blk, 0);
    wait_drain();

    // Random blocks with input gaps
    for (int b = 0; b < 4; b++) push_send(rnd(), 3);
    wait_drain();

    // Backpressure: three blocks fill the pipeline, two more wait for release
    n0 = nout;
    bus.out_ready = 1'b0;
    for (int b = 0; b < 3; b++) push_send(rnd(), 1);
    check_int("bp_in_ready_full", int'(bus.in_ready), 0);
    repeat (2 * N) @(posedge clk);
    #1;
    check_int("bp_in_ready_hold", int'(bus.in_ready), 0);
    check_int("bp_out_valid", int'(bus.out_valid), 1);
    fork
      begin
        push_send(rnd(), 0);
        push_send(rnd(), 0);
      end
      begin
        repeat (50) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check_int("bp_count", nout - n0, 5);

    // Reset during RUN k=100 of the second block while the first is held in the output
    bus.out_ready = 1'b0;
    push_send(rnd(), 0);
    push_send(rnd(), 0);
    lat = 0;
    for (int t = 0; t < 600; t++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = 1;
        break;
      end
    end
    check_int("mid_first_valid", lat, 1);
    repeat (102) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_int("mid_out_valid", int'(bus.out_valid), 0);
    check_int("mid_gen_rst", int'(gen_rst), 1);
    check_vec("mid_out_hash", bus.out_hash, '0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_int("mid_in_ready", int'(bus.in_ready), 1);
    check_int("mid_gen_rst_rel", int'(gen_rst), 0);
    push_send(rnd(), 2);
    wait_drain();

    // Continuous streaming: one result every N+3 cycles, input stalls between blocks
    stall = 0;
    fork
      begin
        for (int b = 0; b < 3; b++) push_send(rnd(), 0);
      end
      begin
        int nr = 0;
        logic pv = 1'b0;
        for (int t = 0; t < 4000 && nr < 3; t++) begin
          @(posedge clk);
          #1;
          if (bus.out_valid && !pv) begin
            rise[nr] = cyc;
            nr++;
          end
          if (!bus.in_ready) stall++;
          pv = bus.out_valid;
        end
        check_int("stream_rises", nr, 3);
      end
    join
    check_int("period01", rise[1] - rise[0], N + 3);
    check_int("period12", rise[2] - rise[1], N + 3);
    check_int("in_ready_stall", int'(stall > 0), 1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/toeplitz_acc.md
# toeplitz_acc

Downstream consumer of `gencol`: buffers raw input bits, drives `gencol`'s reset to align its column sequence, and XOR-accumulates the Toeplitz columns selected by the raw bits. The result is the L-bit extracted hash T·x over GF(2), one hash per N raw bits, delivered over a valid/ready output. It double-buffers the input, so the next block fills while the current one is hashed.

## Interface
- `N`, default 256: raw bits per block; must equal `gencol` N.
- `L`, default 128: hash width; must equal `gencol` L.
- `DW`, default 8: raw input word width; N % DW == 0.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  DW  raw bits; bit 0 is the earliest raw bit.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  fill buffer can accept a word.
- `gen_rst`  out  1  registered; drives `gencol.reset` (active-high).
- `col`  in  L  current `gencol` column output.
- `out_hash`  out  L  hash result.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.

`gencol` is instantiated with STRIDE=1.

## Operation
- Fill buffer: N bits plus a word counter `fcnt` (0..N/DW).
  - `in_ready = (fcnt != N/DW)`.
  - On `in_valid && in_ready`, the word is stored at bits [fcnt*DW +: DW] and `fcnt` increments.
  - Raw bit j of the block is fill bit j.
- Process buffer: N bits `pbuf`; accumulator `acc` is L bits; column index `k` runs 0..N-1.
- FSM states: IDLE, ARM, RUN, DONE.
  - IDLE: if `fcnt == N/DW`, copy fill→`pbuf`, clear `fcnt`, set `gen_rst`, go to ARM. Otherwise stay.
  - ARM (1 cycle): `gen_rst` is high. Clear `gen_rst`, clear `acc`, set `k=0`, go to RUN.
  - RUN (N cycles): `acc <= acc ^ (pbuf[k] ? col : 0)`, then `k++`. After k = N-1, go to DONE.
  - DONE: if `!out_valid || out_ready`, load `out_hash <= acc`, set `out_valid`, go to IDLE. Otherwise stall in DONE with `acc` held.
- Output handshake:
  - A transfer occurs on `out_valid && out_ready`.
  - `out_valid` clears on a transfer unless DONE reloads it in the same cycle, in which case it stays 1 and `out_hash` takes the new value.
  - `out_hash` is stable while `out_valid && !out_ready`.
- Filling continues in every state. A full fill buffer simply holds until the FSM next passes through IDLE.
- The gencol free-running wrap (every N cycles) never occurs inside RUN, because RUN lasts exactly N cycles after a gencol reset.

## Timing
- Reset (asynchronous assert) drives:
  - state = IDLE
  - `fcnt` = 0
  - `acc` = 0
  - `out_hash` = 0
  - `out_valid` = 0
  - `gen_rst` = 1, which holds `gencol` in reset.
- On the first clock edge after reset release, `gen_rst` goes to 0.
- Reset mid-operation discards the block in flight and any partially filled block. No partial hash is ever emitted.
- `in_ready` is combinational from `fcnt` and is 1 the cycle after reset release.
- Column alignment:
  - `gen_rst` is high during ARM, so `gencol` loads `col0` at the ARM→RUN edge.
  - RUN cycle k samples `col` = column k, i.e. `col0` at k=0.
- Latency: last word accepted at edge E0 → fill→`pbuf` copy at edge E1 → ARM → RUN over edges E3..E(N+2) → `out_valid` high after edge E(N+3), if the output register is free.
- Minimum block period: max(N/DW, N+3) cycles, since IDLE, ARM, N cycles of RUN and DONE are each one cycle at minimum.
- Backpressure: with `out_ready` = 0, at most three blocks are held (output register, stalled `acc`, full fill buffer). `in_ready` then stays 0.

## Test plan
- All-zero block (32 words of 0x00), `out_ready` = 1 → one `out_valid` pulse, `out_hash` = 0, N+3 edges after the last accepted word.
- Block with only bit 0 set (word0 = 0x01, rest 0x00) → `out_hash` == `col0`. With only bit 1 set (word0 = 0x02) → `out_hash` == column 1 (`{row0[N-1], col0[L-1:1]}`).
- Random `row0`, `col0` and 4 random blocks with random `in_valid` gaps → each `out_hash` equals the GF(2) Toeplitz-product reference model, in order.
- `out_ready` held 0 while streaming 5 blocks → `in_ready` falls to 0 after the third block's last word. Releasing `out_ready` then yields 5 correct hashes in order, with none lost or duplicated.
- Reset asserted at RUN k=100 → `out_valid` = 0 and `gen_rst` = 1 immediately (asynchronously); `in_ready` = 1 after release. The next full block produces the correct hash with no stale result.
- Continuous `in_valid` = 1 and `out_ready` = 1, N = 256, DW = 8 → `out_valid` pulses every 259 cycles and `in_ready` stalls between blocks.
